// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Signal bundle between the IF/MEM pipeline ports, the arbiter
//             and the memory bus wrapper. The arbiter uses the slave modport;
//             the pipeline/bus side (or a bench) uses the master modport.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if;
   // instruction-fetch port
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        if_err;

   // memory-stage port
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_sel;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        mem_err;

   // pipeline stall
   logic        stall;

   // shared memory bus
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_sel;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ready;

   // arbiter side
   modport slave (
      input  if_req, if_addr,
      input  mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
      input  bus_rdata, bus_ready,
      output if_rdata, if_ack, if_err,
      output mem_rdata, mem_ack, mem_err,
      output stall,
      output bus_req, bus_we, bus_addr, bus_sel, bus_wdata
   );

   // requester / bus side
   modport master (
      output if_req, if_addr,
      output mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
      output bus_rdata, bus_ready,
      input  if_rdata, if_ack, if_err,
      input  mem_rdata, mem_ack, mem_err,
      input  stall,
      input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported memory bus between the instruction
//             fetch port (word reads) and the memory-stage port (reads and
//             byte-lane writes). The granted command is registered onto the
//             bus, the arbiter waits for bus_ready (or a timeout) and returns
//             a one-cycle ack plus read data to the winner.
//  Options  : MEM_ARB_ROUND_ROBIN_EN - round-robin tie break instead of the
//             default fixed MEM-over-IF priority.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,  // 1..65535
   parameter int unsigned CNT_WIDTH      = 16    // must hold TIMEOUT_CYCLES
) (
   input wire           clock,
   input wire           reset,   // asynchronous, active low
   mem_port_arbiter_if.slave arb
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANT_IF  = 2'd1,
      GRANT_MEM = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   state_t                 state, state_n;
   logic [CNT_WIDTH-1:0]   cnt, cnt_n;

   logic                   bus_req_q, bus_req_n;
   logic                   bus_we_q, bus_we_n;
   logic [31:0]            bus_addr_q, bus_addr_n;
   logic [3:0]             bus_sel_q, bus_sel_n;
   logic [31:0]            bus_wdata_q, bus_wdata_n;

   logic                   if_ack_q, if_ack_n;
   logic                   if_err_q, if_err_n;
   logic [31:0]            if_rdata_q, if_rdata_n;
   logic                   mem_ack_q, mem_ack_n;
   logic                   mem_err_q, mem_err_n;
   logic [31:0]            mem_rdata_q, mem_rdata_n;

   // set once the granted requester lets go of its request mid-transaction;
   // the bus cycle still completes but the ack is swallowed
   logic                   abandon_q, abandon_n;

   logic                   if_elig;
   logic                   mem_elig;
   logic                   grant_if;
   logic                   grant_mem;
   logic                   timeout_hit;

   // a port whose ack is high this cycle must not be granted again on the
   // request it is still holding
   assign if_elig     = arb.if_req  & ~if_ack_q;
   assign mem_elig    = arb.mem_req & ~mem_ack_q;
   assign timeout_hit = (cnt == CNT_LIMIT);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // 1 = MEM was granted most recently; reset value makes the first tie go to IF
   logic last_mem;

   // remember which port won the most recent grant
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_mem <= 1'b1;
      end else if (grant_mem) begin
         last_mem <= 1'b1;
      end else if (grant_if) begin
         last_mem <= 1'b0;
      end
   end

   // round-robin pick: on a tie the port that did not win last time goes first
   always_comb begin
      grant_mem = 1'b0;
      grant_if  = 1'b0;
      if (state == IDLE) begin
         grant_mem = mem_elig & (~if_elig | ~last_mem);
         grant_if  = if_elig & ~grant_mem;
      end
   end
`else
   // fixed priority: MEM carries the older instruction, so it wins ties
   always_comb begin
      grant_mem = 1'b0;
      grant_if  = 1'b0;
      if (state == IDLE) begin
         grant_mem = mem_elig;
         grant_if  = if_elig & ~mem_elig;
      end
   end
`endif

   // next-state and next-output logic for the grant/wait/complete sequence
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      bus_req_n   = bus_req_q;
      bus_we_n    = bus_we_q;
      bus_addr_n  = bus_addr_q;
      bus_sel_n   = bus_sel_q;
      bus_wdata_n = bus_wdata_q;
      if_ack_n    = 1'b0;
      if_err_n    = 1'b0;
      if_rdata_n  = if_rdata_q;
      mem_ack_n   = 1'b0;
      mem_err_n   = 1'b0;
      mem_rdata_n = mem_rdata_q;
      abandon_n   = abandon_q;

      case (state)
         IDLE: begin
            // bus_ready seen here belongs to nobody and is ignored
            cnt_n     = '0;
            bus_req_n = 1'b0;
            if (grant_mem) begin
               state_n     = GRANT_MEM;
               bus_req_n   = 1'b1;
               bus_we_n    = arb.mem_we;
               bus_addr_n  = arb.mem_addr;
               bus_sel_n   = arb.mem_we ? arb.mem_sel : 4'b1111;
               bus_wdata_n = arb.mem_wdata;
               abandon_n   = 1'b0;
            end else if (grant_if) begin
               state_n     = GRANT_IF;
               bus_req_n   = 1'b1;
               bus_we_n    = 1'b0;
               bus_addr_n  = arb.if_addr;
               bus_sel_n   = 4'b1111;
               bus_wdata_n = '0;
               abandon_n   = 1'b0;
            end
         end

         GRANT_IF: begin
            if (!arb.if_req) begin
               abandon_n = 1'b1;
            end
            // bus_ready takes precedence over a coincident timeout
            if (arb.bus_ready || timeout_hit) begin
               state_n   = IDLE;
               bus_req_n = 1'b0;
               cnt_n     = '0;
               if (arb.if_req && !abandon_q) begin
                  if_ack_n   = 1'b1;
                  if_err_n   = ~arb.bus_ready;
                  if_rdata_n = arb.bus_ready ? arb.bus_rdata : 32'h0;
               end
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end

         GRANT_MEM: begin
            if (!arb.mem_req) begin
               abandon_n = 1'b1;
            end
            if (arb.bus_ready || timeout_hit) begin
               state_n   = IDLE;
               bus_req_n = 1'b0;
               cnt_n     = '0;
               if (arb.mem_req && !abandon_q) begin
                  mem_ack_n   = 1'b1;
                  mem_err_n   = ~arb.bus_ready;
                  // writes return zero data
                  mem_rdata_n = (arb.bus_ready && !bus_we_q) ? arb.bus_rdata : 32'h0;
               end
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end

         default: begin
            state_n   = IDLE;
            bus_req_n = 1'b0;
            cnt_n     = '0;
         end
      endcase
   end

   // state and registered outputs; reset drops bus_req without a clock edge
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_sel_q   <= '0;
         bus_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         if_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         mem_ack_q   <= 1'b0;
         mem_err_q   <= 1'b0;
         mem_rdata_q <= '0;
         abandon_q   <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         bus_req_q   <= bus_req_n;
         bus_we_q    <= bus_we_n;
         bus_addr_q  <= bus_addr_n;
         bus_sel_q   <= bus_sel_n;
         bus_wdata_q <= bus_wdata_n;
         if_ack_q    <= if_ack_n;
         if_err_q    <= if_err_n;
         if_rdata_q  <= if_rdata_n;
         mem_ack_q   <= mem_ack_n;
         mem_err_q   <= mem_err_n;
         mem_rdata_q <= mem_rdata_n;
         abandon_q   <= abandon_n;
      end
   end

   assign arb.bus_req   = bus_req_q;
   assign arb.bus_we    = bus_we_q;
   assign arb.bus_addr  = bus_addr_q;
   assign arb.bus_sel   = bus_sel_q;
   assign arb.bus_wdata = bus_wdata_q;
   assign arb.if_ack    = if_ack_q;
   assign arb.if_err    = if_err_q;
   assign arb.if_rdata  = if_rdata_q;
   assign arb.mem_ack   = mem_ack_q;
   assign arb.mem_err   = mem_err_q;
   assign arb.mem_rdata = mem_rdata_q;

   // the only combinational output: a request is pending until its ack
   assign arb.stall = (arb.if_req & ~if_ack_q) | (arb.mem_req & ~mem_ack_q);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory bus between two requesters: the instruction-fetch port (IF, read-only word) and the memory stage port (MEM, LW/LB read, SW/SB write with byte select).
- Sits between the pipeline stages and the memory/bus wrapper.
- Registers the granted command onto the bus and waits for `bus_ready`. It returns read data plus a one-cycle ack to the winner.
- The other requester stalls until it is served.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles to wait for `bus_ready` before aborting with error (1..65535).
- CNT_WIDTH, 16: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  IF read request, held until if_ack.
- if_addr  input  32  IF word address.
- if_rdata  output  32  IF read data, valid while if_ack=1.
- if_ack  output  1  one-cycle completion pulse for IF.
- if_err  output  1  with if_ack: transaction timed out.
- mem_req  input  1  MEM request, held until mem_ack.
- mem_we  input  1  1=write, 0=read.
- mem_addr  input  32  MEM byte address.
- mem_sel  input  4  byte-lane select for writes; bit3 = bits[31:24].
- mem_wdata  input  32  write data, already lane-replicated by the stage.
- mem_rdata  output  32  MEM read data, valid while mem_ack=1.
- mem_ack  output  1  one-cycle completion pulse for MEM.
- mem_err  output  1  with mem_ack: transaction timed out.
- stall  output  1  combinational OR of (if_req & ~if_ack) and (mem_req & ~mem_ack); feeds pipeline stall.
- bus_req  output  1  registered bus request.
- bus_we  output  1  registered write enable.
- bus_addr  output  32  registered address.
- bus_sel  output  4  registered byte select; 4'b1111 for all reads.
- bus_wdata  output  32  registered write data.
- bus_rdata  input  32  bus read data, valid with bus_ready.
- bus_ready  input  1  bus completion strobe.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE.
  - All bus_* outputs 0.
  - if_ack, mem_ack, if_err, mem_err = 0.
  - if_rdata, mem_rdata = 0.
  - Timeout counter = 0.
  - Priority pointer = MEM.
- Reset asserted mid-transaction: bus_req drops immediately (asynchronously). No ack is issued. Requesters must re-request after reset releases.
- FSM states: IDLE, GRANT_IF, GRANT_MEM.
- IDLE:
  - Arbitrate among eligible requests.
  - Fixed priority: MEM over IF, since MEM holds the older instruction.
  - The winner's command is registered onto the bus_*. For IF: we=0, sel=4'b1111, wdata=0. bus_req=1 from the next cycle.
  - Go to GRANT_x.
  - No request: stay in IDLE, bus_req=0.
- GRANT_x, bus_ready=1:
  - Capture bus_rdata into x_rdata (0 for writes).
  - x_ack=1 for exactly the next cycle.
  - bus_req=0, counter cleared, go to IDLE.
- GRANT_x, bus_ready=0:
  - Counter increments and bus outputs hold stable.
  - When counter == TIMEOUT_CYCLES-1: x_ack=1 and x_err=1 next cycle, x_rdata=0, bus_req=0, go to IDLE.
- A requester is ineligible in the cycle its ack is high. This prevents a double-grant on a request that is still held in the ack cycle.
- Minimum latency: request seen in IDLE at cycle N → bus_req at N+1 → bus_ready at N+1 → ack at N+2. At least one IDLE cycle separates consecutive bus transactions.
- Outputs other than stall are registered. x_ack and x_err are never high for both ports in the same cycle.
- A request dropped before its ack is a protocol violation. The arbiter completes the bus transaction and discards the ack.
- bus_ready while in IDLE is ignored.
- If the bus_ready strobe and the timeout limit fall in the same cycle, bus_ready wins: normal ack, err=0.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. Ties in IDLE go to the port not granted most recently. The pointer updates on every grant and is reset to MEM, so the first tie goes to IF.
- Undefined: fixed priority MEM > IF. The pointer logic is absent.

Test Plan:
- IF-only read: if_req=1, if_addr=0x100, bus_ready=1 on first bus_req cycle with bus_rdata=0xDEADBEEF → bus_addr=0x100, sel=4'b1111, if_ack pulse at cycle+2, if_rdata=0xDEADBEEF, stall low after ack.
- Conflict: if_req and mem_req (SW, addr 0x20, wdata 0x11223344) asserted together → MEM granted first (bus_we=1, sel=4'b1111), then IF. Under MEM_ARB_ROUND_ROBIN_EN a second simultaneous pair grants IF first.
- SB lane: mem_we=1, mem_sel=4'b0010, wdata=0xABABABAB → bus_sel=4'b0010 registered unchanged; mem_ack with mem_err=0.
- Timeout: TIMEOUT_CYCLES=4, mem_req read, bus_ready held 0 → mem_ack=1 and mem_err=1 exactly 4 cycles after bus_req rises, mem_rdata=0, bus_req=0.
- Held-request re-grant guard: IF keeps if_req=1 through its ack cycle → no second bus_req in the ack cycle; a new grant follows one cycle later.
- Async reset at wait cycle 2 of a MEM transaction → bus_req=0 without a clock edge, no mem_ack. After release, state is IDLE and a fresh request completes normally.
